// File: rtl/i2c_target_fsm.sv
// I2C target protocol engine: oversamples SCL/SDA, decodes START/STOP, matches
// a 7-bit address and moves write/read bytes between the bus and local ports.
module i2c_target_fsm #(
   parameter logic [6:0]  TARGET_ADDR = 7'h42,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy,
   output logic       rw
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_DATA,
      S_RD_ACK,
      S_WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl;
   logic                   sda;
   logic                   scl_prev;
   logic                   sda_prev;

   // Synchronisers idle high so reset never fabricates a bus edge from a quiet bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep every stage sampling the previous value.
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_prev <= scl_sync[SYNC_STAGES-1];
         sda_prev <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl = scl_sync[SYNC_STAGES-1];
   assign sda = sda_sync[SYNC_STAGES-1];

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   assign scl_rise  = scl & ~scl_prev;
   assign scl_fall  = ~scl & scl_prev;
   assign start_det = scl & scl_prev & sda_prev & ~sda;
   assign stop_det  = scl & scl_prev & ~sda_prev & sda;

   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] shift;
   logic       addr_match;
   logic       ack_sent;
   logic       master_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         bit_cnt    <= 4'd0;
         shift      <= 8'h00;
         addr_match <= 1'b0;
         ack_sent   <= 1'b0;
         master_ack <= 1'b0;
         sda_oe     <= 1'b0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         tx_req     <= 1'b0;
         busy       <= 1'b0;
         rw         <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;

         // Frame delimiters override any SCL edge seen in the same cycle.
         if (stop_det) begin
            state   <= S_IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= 4'd0;
         end else if (start_det) begin
            state   <= S_ADDR;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= 4'd0;
         end else begin
            case (state)
               S_IDLE: begin
                  bit_cnt <= 4'd0;
               end

               S_ADDR: begin
                  if (scl_rise) begin
                     shift   <= {shift[6:0], sda};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        rw         <= sda;
                        // The general-call address is never claimed.
                        addr_match <= (shift[6:0] == TARGET_ADDR) && (shift[6:0] != 7'h00);
                     end
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     bit_cnt <= 4'd0;
                     if (addr_match) begin
                        sda_oe <= 1'b1;
                        busy   <= 1'b1;
                        state  <= S_ADDR_ACK;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= S_WAIT_STOP;
                     end
                  end
               end

               S_ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt <= 4'd0;
                     if (rw) begin
                        shift  <= tx_data;
                        tx_req <= 1'b1;
                        sda_oe <= ~tx_data[7];
                        state  <= S_RD_DATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= S_WR_DATA;
                     end
                  end
               end

               S_WR_DATA: begin
                  if (scl_rise) begin
                     shift   <= {shift[6:0], sda};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        rx_data  <= {shift[6:0], sda};
                        rx_valid <= 1'b1;
                     end
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     sda_oe   <= rx_ready;
                     ack_sent <= rx_ready;
                     bit_cnt  <= 4'd0;
                     state    <= S_WR_ACK;
                  end
               end

               S_WR_ACK: begin
                  if (scl_fall) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 4'd0;
                     state   <= ack_sent ? S_WR_DATA : S_WAIT_STOP;
                  end
               end

               S_RD_DATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe     <= 1'b0;
                        bit_cnt    <= 4'd0;
                        master_ack <= 1'b0;
                        state      <= S_RD_ACK;
                     end else begin
                        shift  <= {shift[6:0], 1'b0};
                        sda_oe <= ~shift[6];
                     end
                  end
               end

               S_RD_ACK: begin
                  if (scl_rise) begin
                     master_ack <= ~sda;
                  end else if (scl_fall) begin
                     bit_cnt <= 4'd0;
                     if (master_ack) begin
                        shift  <= tx_data;
                        tx_req <= 1'b1;
                        sda_oe <= ~tx_data[7];
                        state  <= S_RD_DATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= S_WAIT_STOP;
                     end
                  end
               end

               S_WAIT_STOP: begin
                  sda_oe <= 1'b0;
               end

               default: begin
                  sda_oe <= 1'b0;
                  state  <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_fsm.sv
// Directed bench for i2c_target_fsm: a bit-banged bus master drives table vectors
// for write transactions plus hand sequences for read, repeated START and reset.
module tb_i2c_target_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic       busy;
   logic       rw;

   // Open-drain bus: the target can only pull the master's SDA low.
   assign scl_in = m_scl;
   assign sda_in = m_sda & ~sda_oe;

   i2c_target_fsm #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda_oe   (sda_oe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .busy     (busy),
      .rw       (rw)
   );

   always #5 clk = ~clk;

   int rx_pulses = 0;
   int tx_pulses = 0;
   int oe_cycles = 0;

   always @(negedge clk) begin
      rx_pulses <= rx_pulses + (rx_valid ? 1 : 0);
      tx_pulses <= tx_pulses + (tx_req ? 1 : 0);
      oe_cycles <= oe_cycles + (sda_oe ? 1 : 0);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1;
      wait_clks(4);
      m_scl = 1'b1;
      wait_clks(8);
      m_sda = 1'b0;
      wait_clks(8);
      m_scl = 1'b0;
      wait_clks(4);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0;
      wait_clks(4);
      m_scl = 1'b1;
      wait_clks(8);
      m_sda = 1'b1;
      wait_clks(8);
   endtask

   // One SCL clock; sda_oe and the resolved bus SDA are sampled mid-high.
   task automatic clock_bit(input logic b, output logic oe_mid, output logic sda_mid);
      m_sda = b;
      wait_clks(4);
      m_scl = 1'b1;
      wait_clks(4);
      oe_mid  = sda_oe;
      sda_mid = sda_in;
      wait_clks(4);
      m_scl = 1'b0;
      wait_clks(4);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack_oe);
      logic o, s;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], o, s);
      clock_bit(1'b1, ack_oe, s);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic give_ack);
      logic o, s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, o, s);
         d[i] = s;
      end
      clock_bit(~give_ack, o, s);
   endtask

   typedef struct {
      logic [7:0] addr_byte;
      logic [7:0] data;
      logic       has_extra;
      logic [7:0] extra;
      logic       ready;
      logic       exp_addr_ack;
      logic       exp_data_ack;
      logic       exp_extra_ack;
      int         exp_rx;
      logic [7:0] exp_rx_data;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       a;
      logic       o;
      logic       s;
      logic [7:0] d1;
      logic [7:0] d2;
      int         rx0;
      int         tx0;
      int         oe0;

      vecs[0] = '{8'h84, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'hA5};
      vecs[1] = '{8'h86, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'hA5};
      vecs[2] = '{8'h84, 8'h5A, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h5A};
      vecs[3] = '{8'h00, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h5A};
      vecs[4] = '{8'h84, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'hFF};

      wait_clks(3);
      check("reset sda_oe",   32'(sda_oe),   32'h0);
      check("reset rx_data",  32'(rx_data),  32'h00);
      check("reset rx_valid", 32'(rx_valid), 32'h0);
      check("reset tx_req",   32'(tx_req),   32'h0);
      check("reset busy",     32'(busy),     32'h0);
      check("reset rw",       32'(rw),       32'h0);
      rst_n = 1'b1;
      wait_clks(6);

      // Write transactions from the vector table.
      for (int v = 0; v < 5; v++) begin
         rx_ready = vecs[v].ready;
         rx0 = rx_pulses;
         oe0 = oe_cycles;
         bus_start();
         write_byte(vecs[v].addr_byte, a);
         check($sformatf("v%0d addr ack", v), 32'(a), 32'(vecs[v].exp_addr_ack));
         check($sformatf("v%0d busy", v), 32'(busy), 32'(vecs[v].exp_addr_ack));
         write_byte(vecs[v].data, a);
         check($sformatf("v%0d data ack", v), 32'(a), 32'(vecs[v].exp_data_ack));
         if (vecs[v].has_extra) begin
            write_byte(vecs[v].extra, a);
            check($sformatf("v%0d extra ack", v), 32'(a), 32'(vecs[v].exp_extra_ack));
         end
         check($sformatf("v%0d rx pulses", v), 32'(rx_pulses - rx0), 32'(vecs[v].exp_rx));
         check($sformatf("v%0d rx_data", v), 32'(rx_data), 32'(vecs[v].exp_rx_data));
         if (!vecs[v].exp_addr_ack)
            check($sformatf("v%0d oe cycles", v), 32'(oe_cycles - oe0), 32'h0);
         bus_stop();
         check($sformatf("v%0d busy after stop", v), 32'(busy), 32'h0);
         check($sformatf("v%0d sda_oe after stop", v), 32'(sda_oe), 32'h0);
         wait_clks(4);
      end
      rx_ready = 1'b1;

      // Two-byte read: master ACKs the first byte and NACKs the second.
      tx_data = 8'h3C;
      tx0 = tx_pulses;
      bus_start();
      write_byte(8'h85, a);
      check("read addr ack", 32'(a), 32'h1);
      check("read rw", 32'(rw), 32'h1);
      tx_data = 8'hC3;
      read_byte(d1, 1'b1);
      check("read byte 0", 32'(d1), 32'h3C);
      read_byte(d2, 1'b0);
      check("read byte 1", 32'(d2), 32'hC3);
      check("read tx_req pulses", 32'(tx_pulses - tx0), 32'd2);
      check("read oe after nack", 32'(sda_oe), 32'h0);
      check("read busy before stop", 32'(busy), 32'h1);
      bus_stop();
      check("read busy after stop", 32'(busy), 32'h0);
      wait_clks(4);

      // Repeated START in the middle of bit 4 of a write data byte.
      tx_data = 8'hF0;
      rx0 = rx_pulses;
      bus_start();
      write_byte(8'h84, a);
      check("rs write addr ack", 32'(a), 32'h1);
      clock_bit(1'b1, o, s);
      clock_bit(1'b0, o, s);
      clock_bit(1'b1, o, s);
      bus_start();
      check("rs busy cleared", 32'(busy), 32'h0);
      write_byte(8'h85, a);
      check("rs read addr ack", 32'(a), 32'h1);
      check("rs rw", 32'(rw), 32'h1);
      read_byte(d1, 1'b0);
      check("rs read byte", 32'(d1), 32'hF0);
      check("rs no rx_valid", 32'(rx_pulses - rx0), 32'h0);
      bus_stop();
      wait_clks(4);

      // Reset asserted while the target drives a zero in read bit 3.
      tx_data = 8'h00;
      bus_start();
      write_byte(8'h85, a);
      check("mid-reset addr ack", 32'(a), 32'h1);
      for (int i = 0; i < 4; i++) clock_bit(1'b1, o, s);
      m_sda = 1'b1;
      wait_clks(2);
      check("mid-reset oe before", 32'(sda_oe), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid-reset oe async", 32'(sda_oe), 32'h0);
      check("mid-reset busy",     32'(busy),     32'h0);
      check("mid-reset rw",       32'(rw),       32'h0);
      check("mid-reset rx_data",  32'(rx_data),  32'h00);
      check("mid-reset tx_req",   32'(tx_req),   32'h0);
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(6);
      bus_start();
      write_byte(8'h84, a);
      check("post-reset addr ack", 32'(a), 32'h1);
      check("post-reset busy", 32'(busy), 32'h1);
      bus_stop();
      check("post-reset busy after stop", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
